branch_unit: RTL and testbench
==============================

# branch_unit

Parametrised branch/jump resolution unit for the 8-bit CPU core. It takes a decoded branch operation from the control unit and collects a multi-byte target or offset from the data bus with a counted byte-fetch state machine. It evaluates the condition against the ALU flags, computes an absolute or PC-relative target, and issues a one-cycle PC load to the program counter. A parametrised return-address stack adds CALL/RET support.

## Interface
Parameters:
- DATA_W, 8, data bus width in bits
- ADDR_W, 16, program counter width; must be a multiple of DATA_W; NBYTES = ADDR_W/DATA_W (≥1)
- RAS_DEPTH, 4, return-address stack entries (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  branch request strobe; accepted only in IDLE
- kind  in  2  0=JMP, 1=CALL, 2=RET, 3=reserved (treated as JMP, never taken)
- rel  in  1  1 = PC-relative target, 0 = absolute; ignored for RET
- cond  in  4  condition select, captured with start
- databus  in  DATA_W  target/offset byte
- data_valid  in  1  databus holds a valid byte this cycle
- zflag, cflag, oflag, sflag  in  1 each  ALU flags, sampled in RESOLVE
- pcin  in  ADDR_W  address of the next sequential instruction, sampled in RESOLVE
- busy  out  1  high in FETCH and RESOLVE
- done  out  1  one-cycle pulse when a request completes, taken or not
- pc_load  out  1  one-cycle pulse; PC must load pc_out
- pc_out  out  ADDR_W  branch target; 0 whenever pc_load is low
- ras_err  out  1  sticky stack overflow/underflow flag; cleared only by rst

## Operation
- States: IDLE, FETCH, RESOLVE.
- IDLE, start=1: capture kind/rel/cond, clear the byte counter. RET goes to RESOLVE; all other kinds go to FETCH. start in any other state is ignored.
- FETCH: each cycle with data_valid=1 shifts databus into the target register, MSB byte first, and increments the counter. After NBYTES bytes go to RESOLVE. data_valid=0 stalls with no timeout.
- RESOLVE: lasts one cycle, then returns to IDLE. On its closing edge, done=1 is registered, and pc_load/pc_out are registered if the branch is taken.
- Conditions:
  - 0 always
  - 1 eq: z
  - 2 neq: !z
  - 3 ltu: c
  - 4 leu: c|z
  - 5 gtu: !(c|z)
  - 6 geu: !c
  - 7 lts: o^s
  - 8 les: (o^s)|z
  - 9 gts: !(o^s)&!z
  - 10 ges: !(o^s)
  - 11–15 never taken
- Target:
  - rel=0: the assembled word.
  - rel=1: pcin + assembled word, with the word taken as two's-complement ADDR_W and the sum mod 2^ADDR_W (wraps at both ends).
- CALL taken:
  - Push pcin.
  - If the stack is full, set ras_err and leave the stack unchanged; the branch is still taken.
- RET taken:
  - Pop; the target is the popped value.
  - If the stack is empty, set ras_err, and pc_load stays 0 (done still pulses).
- Not taken: no push or pop.
- Stack is LIFO, pointer range 0..RAS_DEPTH.

## Timing
- Reset values: state IDLE, busy=0, done=0, pc_load=0, pc_out=0, ras_err=0, stack pointer 0. Target register and counter are cleared.
- rst mid-operation: abort on the next edge. The partial target is discarded and no pc_load is issued.
- Latency for JMP/CALL with back-to-back data_valid: start in cycle 0, bytes in cycles 1..NBYTES, RESOLVE in cycle NBYTES+1, and done/pc_load high in cycle NBYTES+2. Default parameters: cycle 4.
- RET: start in cycle 0, RESOLVE in cycle 1, outputs in cycle 2.
- Earliest next start is in the cycle done is high, since the block is already in IDLE.
- A data_valid in IDLE or RESOLVE is ignored.

## Configuration
- BRANCH_UNIT_RAS_EN defined: return-address stack present as described above.
- BRANCH_UNIT_RAS_EN undefined:
  - No stack storage.
  - CALL behaves exactly as JMP (no push).
  - RET completes with done=1, pc_load=0.
  - ras_err is tied 0.

## Test plan
- Absolute JMP: reset, start kind=0 cond=0 rel=0, bytes 0x12 then 0x34 → pc_load=1, pc_out=0x1234 in cycle 4, and pc_out=0 in cycle 5.
- Relative wrap: pcin=0xFFF0, rel=1, bytes 0x00,0x20 → pc_out=0x0010. With pcin=0x0005 and bytes 0xFF,0xFB → pc_out=0x0000.
- Conditions: sweep cond 0–15 over all 16 z/c/o/s combinations → pc_load matches the table. Example: cond=9 with o=1, s=1, z=0 → taken; cond=12 → never taken, done=1.
- Stack:
  - CALL ×4 with pcin 0x0100..0x0103 → no error.
  - Fifth CALL → ras_err=1 while the branch is still taken.
  - RET ×4 → pc_out 0x0103, 0x0102, 0x0101, 0x0100.
  - Fifth RET → pc_load=0 while done=1.
- Stall/ignore: data_valid gaps of 3 cycles between bytes → result correct, busy held. A start during busy → no effect.
- Reset mid-FETCH: rst after the first byte → busy=0 and no pc_load. A subsequent JMP with 0xAB,0xCD → pc_out=0xABCD.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit: branch/jump resolution for the 8-bit core.
// Collects an NBYTES-wide target (MSB byte first) from databus, evaluates the
// selected condition against the ALU flags, and issues a one-cycle PC load.
// Optional feature macro: BRANCH_UNIT_RAS_EN enables the return-address stack
// (CALL pushes, RET pops). Without it CALL acts as JMP and RET never loads.
//
// Handshake: the only input handshake is data_valid. A byte is consumed on
// every rising edge in FETCH where data_valid=1, and there is no backpressure.
// data_valid outside FETCH is ignored, and so is start outside IDLE.
module branch_unit #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        kind,
    input  logic              rel,
    input  logic [3:0]        cond,
    input  logic [DATA_W-1:0] databus,
    input  logic              data_valid,
    input  logic              zflag,
    input  logic              cflag,
    input  logic              oflag,
    input  logic              sflag,
    input  logic [ADDR_W-1:0] pcin,
    output logic              busy,
    output logic              done,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ras_err,
    output logic [1:0]        dbg_state
);

    localparam int NBYTES = ADDR_W / DATA_W;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    localparam logic [1:0] K_CALL = 2'd1;
    localparam logic [1:0] K_RET  = 2'd2;
    localparam logic [1:0] K_RSVD = 2'd3;

    // Reject parameter sets the byte-assembly logic cannot handle.
    if (RAS_DEPTH < 1 || NBYTES < 1 || NBYTES * DATA_W != ADDR_W) begin : g_param_check
        $error("branch_unit: bad parameters");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         kind_q;
    logic               rel_q;
    logic [3:0]         cond_q;
    logic [ADDR_W-1:0]  target_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_byte;
    logic               cond_ok;
    logic               taken;
    logic [ADDR_W-1:0]  jmp_target;
    logic               res_load;
    logic [ADDR_W-1:0]  res_target;

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;
    assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: RET needs no bytes and goes straight to RESOLVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (kind == K_RET) ? RESOLVE : FETCH;
            FETCH:   if (data_valid && last_byte) state_d = RESOLVE;
            RESOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and MSB-first byte assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q   <= '0;
            rel_q    <= 1'b0;
            cond_q   <= '0;
            target_q <= '0;
            cnt_q    <= '0;
        end else if (state_q == IDLE && start) begin
            kind_q   <= kind;
            rel_q    <= rel;
            cond_q   <= cond;
            target_q <= '0;
            cnt_q    <= '0;
        end else if (state_q == FETCH && data_valid) begin
            target_q <= (target_q << DATA_W) | ADDR_W'(databus);
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Condition evaluation; the reserved kind is never taken.
    always_comb begin
        cond_ok = 1'b0;
        case (cond_q)
            4'd0:    cond_ok = 1'b1;
            4'd1:    cond_ok = zflag;
            4'd2:    cond_ok = !zflag;
            4'd3:    cond_ok = cflag;
            4'd4:    cond_ok = cflag | zflag;
            4'd5:    cond_ok = !(cflag | zflag);
            4'd6:    cond_ok = !cflag;
            4'd7:    cond_ok = oflag ^ sflag;
            4'd8:    cond_ok = (oflag ^ sflag) | zflag;
            4'd9:    cond_ok = !(oflag ^ sflag) & !zflag;
            4'd10:   cond_ok = !(oflag ^ sflag);
            default: cond_ok = 1'b0;
        endcase
        taken = cond_ok && (kind_q != K_RSVD);
    end

    // Relative targets add as two's complement and wrap mod 2^ADDR_W.
    assign jmp_target = rel_q ? (pcin + target_q) : target_q;

`ifdef BRANCH_UNIT_RAS_EN
    localparam int SP_W  = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic              ras_err_q;
    logic              ras_full, ras_empty;
    logic              push_en, pop_en;
    logic [ADDR_W-1:0] ras_top;

    assign ras_full  = (sp_q == SP_W'(RAS_DEPTH));
    assign ras_empty = (sp_q == '0);
    assign ras_top   = ras_mem[IDX_W'(sp_q - SP_W'(1))];
    assign push_en   = (state_q == RESOLVE) && taken && (kind_q == K_CALL) && !ras_full;
    assign pop_en    = (state_q == RESOLVE) && taken && (kind_q == K_RET) && !ras_empty;
    assign ras_err   = ras_err_q;

    // Stack pointer and sticky overflow/underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q      <= '0;
            ras_err_q <= 1'b0;
        end else if (state_q == RESOLVE && taken) begin
            if (kind_q == K_CALL && ras_full)  ras_err_q <= 1'b1;
            if (kind_q == K_RET  && ras_empty) ras_err_q <= 1'b1;
            if (push_en) sp_q <= sp_q + SP_W'(1);
            if (pop_en)  sp_q <= sp_q - SP_W'(1);
        end
    end

    // Stack storage; contents need no reset since sp gates every read.
    always_ff @(posedge clk) begin
        if (push_en) ras_mem[IDX_W'(sp_q)] <= pcin;
    end

    // Resolution: RET loads the popped address, others the computed target.
    always_comb begin
        res_load   = 1'b0;
        res_target = jmp_target;
        if (kind_q == K_RET) begin
            res_load   = taken && !ras_empty;
            res_target = ras_top;
        end else begin
            res_load   = taken;
        end
    end
`else
    assign ras_err = 1'b0;

    // Resolution without a stack: RET never loads, CALL is a plain jump.
    always_comb begin
        res_load   = 1'b0;
        res_target = jmp_target;
        if (kind_q != K_RET) res_load = taken;
    end
`endif

    // Registered one-cycle done/pc_load pulses; pc_out is zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            pc_load <= 1'b0;
            pc_out  <= '0;
        end else begin
            done    <= 1'b0;
            pc_load <= 1'b0;
            pc_out  <= '0;
            if (state_q == RESOLVE) begin
                done <= 1'b1;
                if (res_load) begin
                    pc_load <= 1'b1;
                    pc_out  <= res_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit (default parameters). Driver tasks push the expected
// {pc_load, pc_out, ras_err} for each request; a monitor pops it on done.
module tb_branch_unit;

`ifdef BRANCH_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    localparam int W = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  kind = '0;
    logic        rel = 1'b0;
    logic [3:0]  cond = '0;
    logic [7:0]  databus = '0;
    logic        data_valid = 1'b0;
    logic        zflag = 1'b0, cflag = 1'b0, oflag = 1'b0, sflag = 1'b0;
    logic [15:0] pcin = '0;
    logic        busy, done, pc_load, ras_err;
    logic [15:0] pc_out;
    logic [1:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    logic         exp_err = 1'b0;
    int           n_cmp = 0;
    int           n_fail = 0;

    branch_unit #(.DATA_W(8), .ADDR_W(16), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .kind(kind), .rel(rel), .cond(cond),
        .databus(databus), .data_valid(data_valid),
        .zflag(zflag), .cflag(cflag), .oflag(oflag), .sflag(sflag),
        .pcin(pcin), .busy(busy), .done(done), .pc_load(pc_load),
        .pc_out(pc_out), .ras_err(ras_err), .dbg_state(dbg_state)
    );

    // Clock and global watchdog.
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Reference condition table, flags packed {z, c, o, s}.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, o, s;
        {z, cy, o, s} = f;
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return ~z;
            4'd3:  return cy;
            4'd4:  return cy | z;
            4'd5:  return ~(cy | z);
            4'd6:  return ~cy;
            4'd7:  return o ^ s;
            4'd8:  return (o ^ s) | z;
            4'd9:  return ~(o ^ s) & ~z;
            4'd10: return ~(o ^ s);
            default: return 1'b0;
        endcase
    endfunction

    // Issue one request with back-to-back bytes and check its latency.
    task automatic run_branch(input logic [1:0] k, input logic r, input logic [3:0] c,
                              input logic [15:0] word, input logic [15:0] pc,
                              input logic [3:0] f, input logic exp_ld,
                              input logic [15:0] exp_pc, input string name);
        int cycles;
        exp_q.push_back({exp_ld, exp_pc, exp_err});
        kind = k; rel = r; cond = c; pcin = pc;
        {zflag, cflag, oflag, sflag} = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        if (k != 2'd2) begin
            for (int i = 0; i < 2; i++) begin
                databus = (i == 0) ? word[15:8] : word[7:0];
                data_valid = 1'b1;
                tick();
                cycles++;
            end
            data_valid = 1'b0;
        end
        while (!done && cycles < 30) begin
            tick();
            cycles++;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: got no done after %0d cycles", name, cycles);
        end else begin
            check({name, " latency"}, cycles, (k == 2'd2) ? 2 : 4);
        end
    endtask

    // Monitor: pc_out must be zero when pc_load is low; done pops the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (!pc_load) check("pc_out_idle_zero", {16'h0, pc_out}, 32'h0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 required no pending request");
                end else begin
                    check("result{ld,pc,err}", {14'h0, pc_load, pc_out, ras_err},
                          {14'h0, exp_q.pop_front()});
                end
            end else if (pc_load) begin
                n_cmp++; n_fail++;
                $display("FAIL pc_load_without_done: got pc_load=1 required 0");
            end
        end
    end

    // Directed stimulus.
    initial begin
        logic [15:0] w;
        logic        t;

        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset pc_load", pc_load, 0);
        check("reset pc_out", pc_out, 0);
        check("reset ras_err", ras_err, 0);
        check("reset state", dbg_state, 0);
        rst = 1'b0;
        tick();

        // Absolute jump, then relative wrap-around in both directions.
        run_branch(2'd0, 1'b0, 4'd0, 16'h1234, 16'h0000, 4'h0, 1'b1, 16'h1234, "jmp_abs");
        tick();
        run_branch(2'd0, 1'b1, 4'd0, 16'h0020, 16'hFFF0, 4'h0, 1'b1, 16'h0010, "rel_wrap_up");
        run_branch(2'd0, 1'b1, 4'd0, 16'hFFFB, 16'h0005, 4'h0, 1'b1, 16'h0000, "rel_wrap_down");
        run_branch(2'd3, 1'b0, 4'd0, 16'h4444, 16'h0000, 4'h0, 1'b0, 16'h0000, "reserved_kind");

        // Condition sweep over every flag combination.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                w = 16'h1000 + 16'(c * 16 + f);
                t = cond_model(4'(c), 4'(f));
                run_branch(2'd0, 1'b0, 4'(c), w, 16'h0000, 4'(f), t, t ? w : 16'h0000, "cond_sweep");
            end
        end

        // Stall with gaps, ignored data_valid in IDLE, ignored start while busy.
        exp_q.push_back({1'b1, 16'h5AC3, exp_err});
        databus = 8'hEE; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        kind = 2'd0; rel = 1'b0; cond = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        databus = 8'h5A; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1); kind = (i == 1) ? 2'd2 : 2'd0;
            tick();
            check("stall busy", busy, 1);
        end
        start = 1'b0; kind = 2'd0;
        databus = 8'hC3; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("stall resolve busy", busy, 1);
        tick();
        check("stall done", done, 1);

        // Return-address stack: four pushes, overflow, four pops, underflow.
        for (int i = 0; i < 4; i++)
            run_branch(2'd1, 1'b0, 4'd0, 16'h2000, 16'h0100 + 16'(i), 4'h0, 1'b1, 16'h2000, "call");
        check("no err after 4 calls", ras_err, 0);
        exp_err = RAS_EN;
        run_branch(2'd1, 1'b0, 4'd0, 16'h2000, 16'h0104, 4'h0, 1'b1, 16'h2000, "call_overflow");
        for (int i = 0; i < 4; i++)
            run_branch(2'd2, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'h0, RAS_EN,
                       RAS_EN ? 16'h0103 - 16'(i) : 16'h0000, "ret");
        run_branch(2'd2, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'h0, 1'b0, 16'h0000, "ret_underflow");

        // Reset in the middle of FETCH, then a clean jump.
        start = 1'b1; kind = 2'd0; rel = 1'b0; cond = 4'd0;
        tick();
        start = 1'b0;
        databus = 8'h11; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        check("abort busy", busy, 0);
        check("abort ras_err", ras_err, 0);
        repeat (4) tick();
        check("abort no pc_load", pc_load, 0);
        run_branch(2'd0, 1'b0, 4'd0, 16'hABCD, 16'h0000, 4'h0, 1'b1, 16'hABCD, "jmp_after_reset");

        repeat (3) tick();
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
